// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use detection, per-unit multi-cycle busy
// tracking, deferred EX redirects, redirect/flush priority, stall watchdog and counter.
module hazard_stall_ctrl #(
  parameter int RW             = 5,
  parameter int NUM_MC         = 2,
  parameter int LOAD_USE_DEPTH = 1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RW-1:0]     id_rs1_i,
  input  logic [RW-1:0]     id_rs2_i,
  input  logic              id_uses_rs2_i,
  input  logic [RW-1:0]     ex_rd_i,
  input  logic              ex_memread_i,
  input  logic [RW-1:0]     mem_rd_i,
  input  logic              mem_memread_i,
  input  logic              exe_pc_req_i,
  input  logic              csr_pc_req_i,
  input  logic              wfi_req_i,
  input  logic              irq_flush_i,
  input  logic [NUM_MC-1:0] mc_req_i,
  input  logic [NUM_MC-1:0] mc_ack_i,
  output logic              exe_pc_req_o,
  output logic              csr_pc_req_o,
  output logic              wfi_req_o,
  output logic              pc_changed_o,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              id_ex_write_o,
  output logic              ex_mem_write_o,
  output logic              hazard_out_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o,
  output logic              flush_ex_mem_o,
  output logic              flush_mem_wb_o,
  output logic              mc_flush_o,
  output logic [NUM_MC-1:0] mc_busy_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [NUM_MC-1:0] busy_reg;
  logic [NUM_MC-1:0] busy_next;
  logic              pend_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic              mc_stall;
  logic              ex_hit;
  logic              mem_hit;
  logic              ld_use;
  logic              stall_any;
  logic              serve_exe;
  logic              wd_fire;

  // Ack beats a same-cycle req so a zero-latency unit never looks busy.
  for (genvar gi = 0; gi < NUM_MC; gi++) begin : g_busy
    assign busy_next[gi] = mc_ack_i[gi] ? 1'b0 : (mc_req_i[gi] ? 1'b1 : busy_reg[gi]);
  end

  assign mc_stall  = |busy_next;
  assign mc_busy_o = busy_next;

  // x0 is hardwired, so a load targeting it can never create a dependency.
  assign ex_hit  = (ex_rd_i != '0) &&
                   ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
  assign mem_hit = (mem_rd_i != '0) &&
                   ((mem_rd_i == id_rs1_i) || (id_uses_rs2_i && (mem_rd_i == id_rs2_i)));
  assign ld_use  = ((ex_memread_i && ex_hit) ||
                    ((LOAD_USE_DEPTH == 2) && mem_memread_i && mem_hit)) && !(|mc_req_i);

  assign stall_any      = ld_use | mc_stall;
  assign pc_write_o     = !stall_any;
  assign if_id_write_o  = !stall_any;
  assign id_ex_write_o  = !mc_stall;
  assign ex_mem_write_o = !mc_stall;
  assign hazard_out_o   = ld_use;

  assign mc_flush_o   = csr_pc_req_i | wfi_req_i | irq_flush_i;
  assign csr_pc_req_o = csr_pc_req_i;
  assign wfi_req_o    = wfi_req_i & !csr_pc_req_i;

  // A branch resolved while stalled is held until the pipe can move; higher-priority
  // redirects discard it.
  assign serve_exe    = (exe_pc_req_i | pend_reg) & !stall_any & !mc_flush_o;
  assign exe_pc_req_o = serve_exe;
  assign pc_changed_o = serve_exe | csr_pc_req_i;

  assign flush_if_id_o  = serve_exe | mc_flush_o;
  assign flush_id_ex_o  = serve_exe | mc_flush_o;
  assign flush_ex_mem_o = csr_pc_req_i | wfi_req_i | wd_fire;
  assign flush_mem_wb_o = irq_flush_i;
  assign timeout_o      = wd_fire;
  assign stall_cnt_o    = stall_cnt_reg;

  if (TIMEOUT_CYCLES > 0) begin : g_wd
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt_reg;

    assign wd_fire = mc_stall && (wd_cnt_reg == WD_LAST);

    always_ff @(posedge clk) begin
      if (rst || !mc_stall || wd_fire) begin
        wd_cnt_reg <= '0;
      end else begin
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end
    end
  end else begin : g_no_wd
    assign wd_fire = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || mc_flush_o || wd_fire) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || serve_exe || mc_flush_o) begin
      pend_reg <= 1'b0;
    end else if (exe_pc_req_i && stall_any) begin
      pend_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (!pc_write_o && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: table-driven load-use vectors on a depth-1 and a
// depth-2 instance, then hand sequences for multi-cycle stalls, redirects and watchdog.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic id_uses_rs2, ex_memread, mem_memread;
  logic exe_pc_req, csr_pc_req, wfi_req, irq_flush;
  logic [1:0] mc_req, mc_ack;

  // depth-2 / short watchdog instance (main DUT)
  logic d2_exe_o, d2_csr_o, d2_wfi_o, d2_pcchg, d2_pcw, d2_ifidw, d2_idexw, d2_exmemw;
  logic d2_haz, d2_fl_ifid, d2_fl_idex, d2_fl_exmem, d2_fl_memwb, d2_mcfl, d2_to;
  logic [1:0] d2_busy;
  logic [31:0] d2_scnt;
  // default-parameter instance (depth 1)
  logic d1_exe_o, d1_csr_o, d1_wfi_o, d1_pcchg, d1_pcw, d1_ifidw, d1_idexw, d1_exmemw;
  logic d1_haz, d1_fl_ifid, d1_fl_idex, d1_fl_exmem, d1_fl_memwb, d1_mcfl, d1_to;
  logic [1:0] d1_busy;
  logic [31:0] d1_scnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.RW(5), .NUM_MC(2), .LOAD_USE_DEPTH(2), .TIMEOUT_CYCLES(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs2_i(id_uses_rs2),
    .ex_rd_i(ex_rd), .ex_memread_i(ex_memread), .mem_rd_i(mem_rd), .mem_memread_i(mem_memread),
    .exe_pc_req_i(exe_pc_req), .csr_pc_req_i(csr_pc_req), .wfi_req_i(wfi_req),
    .irq_flush_i(irq_flush), .mc_req_i(mc_req), .mc_ack_i(mc_ack),
    .exe_pc_req_o(d2_exe_o), .csr_pc_req_o(d2_csr_o), .wfi_req_o(d2_wfi_o),
    .pc_changed_o(d2_pcchg), .pc_write_o(d2_pcw), .if_id_write_o(d2_ifidw),
    .id_ex_write_o(d2_idexw), .ex_mem_write_o(d2_exmemw), .hazard_out_o(d2_haz),
    .flush_if_id_o(d2_fl_ifid), .flush_id_ex_o(d2_fl_idex), .flush_ex_mem_o(d2_fl_exmem),
    .flush_mem_wb_o(d2_fl_memwb), .mc_flush_o(d2_mcfl), .mc_busy_o(d2_busy),
    .timeout_o(d2_to), .stall_cnt_o(d2_scnt)
  );

  hazard_stall_ctrl dut1 (
    .clk(clk), .rst(rst), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs2_i(id_uses_rs2),
    .ex_rd_i(ex_rd), .ex_memread_i(ex_memread), .mem_rd_i(mem_rd), .mem_memread_i(mem_memread),
    .exe_pc_req_i(exe_pc_req), .csr_pc_req_i(csr_pc_req), .wfi_req_i(wfi_req),
    .irq_flush_i(irq_flush), .mc_req_i(mc_req), .mc_ack_i(mc_ack),
    .exe_pc_req_o(d1_exe_o), .csr_pc_req_o(d1_csr_o), .wfi_req_o(d1_wfi_o),
    .pc_changed_o(d1_pcchg), .pc_write_o(d1_pcw), .if_id_write_o(d1_ifidw),
    .id_ex_write_o(d1_idexw), .ex_mem_write_o(d1_exmemw), .hazard_out_o(d1_haz),
    .flush_if_id_o(d1_fl_ifid), .flush_id_ex_o(d1_fl_idex), .flush_ex_mem_o(d1_fl_exmem),
    .flush_mem_wb_o(d1_fl_memwb), .mc_flush_o(d1_mcfl), .mc_busy_o(d1_busy),
    .timeout_o(d1_to), .stall_cnt_o(d1_scnt)
  );

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses2;
    logic [4:0] ex_rd;
    logic       ex_mr;
    logic [4:0] mem_rd;
    logic       mem_mr;
    logic [1:0] mc;     // driven on both req and ack
    logic       haz2;   // expected hazard, depth-2 instance
    logic       haz1;   // expected hazard, depth-1 instance
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; ex_rd = 0; ex_memread = 0;
    mem_rd = 0; mem_memread = 0; exe_pc_req = 0; csr_pc_req = 0; wfi_req = 0;
    irq_flush = 0; mc_req = 0; mc_ack = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"ex_ld_rs1",      5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1};
    vecs[1] = '{"ex_ld_x0",       5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[2] = '{"ex_noload",      5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[3] = '{"mem_ld_rs2",     5'd3, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 2'b00, 1'b1, 1'b0};
    vecs[4] = '{"mem_ld_rs2_nu",  5'd3, 5'd7, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[5] = '{"ex_ld_rs2_nu",   5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[6] = '{"ex_ld_rs2",      5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1};
    vecs[7] = '{"ex_ld_mcreq",    5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 2'b01, 1'b0, 1'b0};
    vecs[8] = '{"idle",           5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0};

    idle();
    rst = 1'b1;
    do_reset();

    // Reset state with idle inputs
    #1;
    chk("rst_pcw", d2_pcw, 1); chk("rst_ifidw", d2_ifidw, 1);
    chk("rst_idexw", d2_idexw, 1); chk("rst_exmemw", d2_exmemw, 1);
    chk("rst_haz", d2_haz, 0); chk("rst_flifid", d2_fl_ifid, 0);
    chk("rst_flexmem", d2_fl_exmem, 0); chk("rst_flmemwb", d2_fl_memwb, 0);
    chk("rst_mcfl", d2_mcfl, 0); chk("rst_busy", d2_busy, 0);
    chk("rst_to", d2_to, 0); chk("rst_scnt", d2_scnt, 0);
    chk("rst_pcchg", d2_pcchg, 0); chk("rst_d1_pcw", d1_pcw, 1);
    $display("reset: pcw=%0b busy=%0b scnt=%0d", d2_pcw, d2_busy, d2_scnt);

    // Single-cycle load-use vectors
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; id_uses_rs2 = vecs[i].uses2;
      ex_rd = vecs[i].ex_rd; ex_memread = vecs[i].ex_mr;
      mem_rd = vecs[i].mem_rd; mem_memread = vecs[i].mem_mr;
      mc_req = vecs[i].mc; mc_ack = vecs[i].mc;
      #1;
      chk({vecs[i].name, "_haz2"}, d2_haz, vecs[i].haz2);
      chk({vecs[i].name, "_pcw2"}, d2_pcw, !vecs[i].haz2);
      chk({vecs[i].name, "_ifidw2"}, d2_ifidw, !vecs[i].haz2);
      chk({vecs[i].name, "_idexw2"}, d2_idexw, 1);
      chk({vecs[i].name, "_haz1"}, d1_haz, vecs[i].haz1);
      chk({vecs[i].name, "_pcw1"}, d1_pcw, !vecs[i].haz1);
      $display("vec %s: haz2=%0b haz1=%0b pcw2=%0b", vecs[i].name, d2_haz, d1_haz, d2_pcw);
    end

    // LSU stall of 4 cycles with an EX redirect arriving mid-stall
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      idle();
      if (k == 0) mc_req = 2'b01;
      if (k == 1) exe_pc_req = 1'b1;
      if (k == 4) mc_ack = 2'b01;
      #1;
      chk($sformatf("lsu_pcw_c%0d", k), d2_pcw, (k >= 4));
      chk($sformatf("lsu_idexw_c%0d", k), d2_idexw, (k >= 4));
      chk($sformatf("lsu_exmemw_c%0d", k), d2_exmemw, (k >= 4));
      chk($sformatf("lsu_exeo_c%0d", k), d2_exe_o, (k == 4));
      chk($sformatf("lsu_flifid_c%0d", k), d2_fl_ifid, (k == 4));
      chk($sformatf("lsu_pcchg_c%0d", k), d2_pcchg, (k == 4));
      chk($sformatf("lsu_busy_c%0d", k), d2_busy, (k < 4) ? 2'b01 : 2'b00);
      if (k == 5) chk("lsu_scnt", d2_scnt, 4);
      $display("lsu c%0d: pcw=%0b exe_o=%0b busy=%0b scnt=%0d", k, d2_pcw, d2_exe_o, d2_busy, d2_scnt);
    end

    // CSR + WFI during a busy divider with a pending EX redirect
    do_reset();
    @(negedge clk); idle(); mc_req = 2'b10;
    @(negedge clk); idle(); exe_pc_req = 1'b1;
    @(negedge clk); idle(); csr_pc_req = 1'b1; wfi_req = 1'b1;
    #1;
    chk("csr_csro", d2_csr_o, 1); chk("csr_wfio", d2_wfi_o, 0);
    chk("csr_mcfl", d2_mcfl, 1); chk("csr_flexmem", d2_fl_exmem, 1);
    chk("csr_flifid", d2_fl_ifid, 1); chk("csr_exeo", d2_exe_o, 0);
    chk("csr_pcchg", d2_pcchg, 1); chk("csr_flmemwb", d2_fl_memwb, 0);
    $display("csr: csr_o=%0b wfi_o=%0b mcfl=%0b", d2_csr_o, d2_wfi_o, d2_mcfl);
    @(negedge clk); idle();
    #1;
    chk("csr_busy_after", d2_busy, 0); chk("csr_pcw_after", d2_pcw, 1);
    chk("csr_pend_dropped", d2_exe_o, 0);
    $display("csr+1: busy=%0b exe_o=%0b", d2_busy, d2_exe_o);
    @(negedge clk); idle(); wfi_req = 1'b1;
    #1;
    chk("wfi_wfio", d2_wfi_o, 1); chk("wfi_pcchg", d2_pcchg, 0);
    chk("wfi_mcfl", d2_mcfl, 1); chk("wfi_flexmem", d2_fl_exmem, 1);
    $display("wfi: wfi_o=%0b pcchg=%0b", d2_wfi_o, d2_pcchg);
    @(negedge clk); idle(); irq_flush = 1'b1;
    #1;
    chk("irq_flmemwb", d2_fl_memwb, 1); chk("irq_mcfl", d2_mcfl, 1);
    chk("irq_flexmem", d2_fl_exmem, 0);
    $display("irq: flmemwb=%0b mcfl=%0b", d2_fl_memwb, d2_mcfl);

    // Watchdog: request never acknowledged
    do_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      idle();
      if (k == 0) mc_req = 2'b01;
      #1;
      chk($sformatf("wd_to_c%0d", k), d2_to, (k == 7));
      chk($sformatf("wd_flexmem_c%0d", k), d2_fl_exmem, (k == 7));
      chk($sformatf("wd_pcw_c%0d", k), d2_pcw, (k == 8));
      chk($sformatf("wd_busy_c%0d", k), d2_busy, (k == 8) ? 2'b00 : 2'b01);
      $display("wd c%0d: timeout=%0b pcw=%0b busy=%0b", k, d2_to, d2_pcw, d2_busy);
    end

    // Reset mid-operation drops busy and pending redirect
    do_reset();
    @(negedge clk); idle(); mc_req = 2'b01;
    @(negedge clk); idle(); exe_pc_req = 1'b1;
    @(negedge clk); idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rstmid_busy", d2_busy, 0); chk("rstmid_exeo", d2_exe_o, 0);
    chk("rstmid_pcw", d2_pcw, 1); chk("rstmid_scnt", d2_scnt, 0);
    $display("rst-mid: busy=%0b exe_o=%0b scnt=%0d", d2_busy, d2_exe_o, d2_scnt);
    @(negedge clk); idle();
    #1;
    chk("rstmid_noreplay", d2_exe_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Parametrised pipeline hazard and stall controller for the 5-stage RV core, and the successor to the single-LSU hazard unit. It handles load-use detection at a configurable depth and tracks NUM_MC independent multi-cycle units (LSU, divider, ...) with per-unit busy state. It also latches EX redirects that arrive during a stall, applies a fixed redirect/flush priority, and includes a stall watchdog and a stall performance counter. It sits between decode/EX/CSR/LSU and the pipeline-register enables and flushes.

Parameters:
RW, 5, register-address width
NUM_MC, 2, number of multi-cycle req/ack units (unit 0 = LSU)
LOAD_USE_DEPTH, 1, stages after EX whose load result is not forwardable (1 or 2)
TIMEOUT_CYCLES, 255, continuous multi-cycle stall cycles before the watchdog fires; 0 disables it
CNT_W, 32, stall performance counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs1_i  in  RW  decode rs1
id_rs2_i  in  RW  decode rs2
id_uses_rs2_i  in  1  instruction in ID reads rs2 (0 for loads, I-type)
ex_rd_i  in  RW  EX-stage rd
ex_memread_i  in  1  EX-stage instruction is a load
mem_rd_i  in  RW  MEM-stage rd (used only when LOAD_USE_DEPTH==2)
mem_memread_i  in  1  MEM-stage instruction is a load
exe_pc_req_i  in  1  branch/jump redirect from EX
csr_pc_req_i  in  1  trap/mret redirect from CSR
wfi_req_i  in  1  WFI entry
irq_flush_i  in  1  interrupt flush
mc_req_i  in  NUM_MC  unit request start (one bit per unit)
mc_ack_i  in  NUM_MC  unit completion
exe_pc_req_o, csr_pc_req_o, wfi_req_o  out  1 each  served redirects
pc_changed_o  out  1  any PC redirect served this cycle
pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o  out  1 each  stage write enables
hazard_out_o  out  1  insert bubble into ID/EX
flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o  out  1 each  stage flushes
mc_flush_o  out  1  abort outstanding multi-cycle ops
mc_busy_o  out  NUM_MC  per-unit busy (next-state view)
timeout_o  out  1  one-cycle watchdog pulse
stall_cnt_o  out  CNT_W  cycles with pc_write_o==0

Behaviour:
- Reset: all registers (busy_ff, pend_ff, wd_cnt, stall_cnt) go to 0. With idle inputs, every write enable is 1 and every flush, redirect and pulse output is 0.
- Per-unit busy: busy_next[i] = mc_ack_i[i] ? 0 : mc_req_i[i] ? 1 : busy_ff[i]. Ack wins over a same-cycle req. busy_ff <= busy_next, except it clears on rst, mc_flush_o or the watchdog fire. mc_stall = |busy_next. mc_busy_o = busy_next.
- Load-use:
  - hit(rd) = rd!=0 && (rd==id_rs1_i || (id_uses_rs2_i && rd==id_rs2_i)). x0 never hazards.
  - ld_use = ((ex_memread_i && hit(ex_rd_i)) || (LOAD_USE_DEPTH==2 && mem_memread_i && hit(mem_rd_i))) && !(|mc_req_i).
- Enables:
  - stall_any = ld_use | mc_stall.
  - pc_write_o = if_id_write_o = !stall_any.
  - id_ex_write_o = ex_mem_write_o = !mc_stall.
  - hazard_out_o = ld_use.
- Redirect priority: irq_flush_i > csr_pc_req_i > wfi_req_i > EX.
  - mc_flush_o = csr_pc_req_i | wfi_req_i | irq_flush_i.
  - csr_pc_req_o = csr_pc_req_i. wfi_req_o = wfi_req_i & !csr_pc_req_i.
- EX redirect pending:
  - exe_pc_req_i while stall_any sets pend_ff, next cycle.
  - serve_exe = (exe_pc_req_i | pend_ff) & !stall_any & !mc_flush_o.
  - pend_ff clears on serve_exe or mc_flush_o. exe_pc_req_o = serve_exe.
- pc_changed_o = serve_exe | csr_pc_req_i. WFI does not count.
- Flushes:
  - flush_if_id_o = flush_id_ex_o = serve_exe | mc_flush_o.
  - flush_ex_mem_o = csr_pc_req_i | wfi_req_i | wd_fire.
  - flush_mem_wb_o = irq_flush_i.
- Watchdog (TIMEOUT_CYCLES>0):
  - wd_cnt increments each cycle mc_stall=1 and clears when mc_stall=0 or on fire.
  - wd_fire = mc_stall && wd_cnt==TIMEOUT_CYCLES-1. It asserts timeout_o for exactly that cycle.
  - The following cycle, all busy_ff are 0.
- stall_cnt: increments on each cycle with pc_write_o==0, saturates at all-ones, and is cleared only by rst.
- Reset mid-operation clears busy and pending state. No redirect is replayed after reset.

Test Plan:
- Load x5 in EX, ID reads rs1=x5 -> hazard_out_o=1, pc_write_o=0, id_ex_write_o=1 for 1 cycle. Same with rd=x0 -> no hazard.
- LOAD_USE_DEPTH=2, load x7 in MEM, ID rs2=x7 with id_uses_rs2_i=1 -> stall. Same with id_uses_rs2_i=0 -> no stall.
- mc_req_i=01, ack 4 cycles later -> all write enables 0 for 4 cycles starting at the req cycle and 1 in the ack cycle; stall_cnt_o=4.
- exe_pc_req_i pulses 1 cycle during an LSU stall -> exe_pc_req_o=1 and flush_if_id_o=1 in the ack cycle only, then pend_ff=0.
- csr_pc_req_i with wfi_req_i during a busy divider -> csr_pc_req_o=1, wfi_req_o=0, mc_flush_o=1, flush_ex_mem_o=1, busy cleared next cycle, pending EX dropped.
- TIMEOUT_CYCLES=8, req with no ack -> timeout_o high on the 8th stall cycle, busy 0 on the 9th, enables 1 again.
